// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared encodings for the multi-cycle shift sequencer:
//                operation codes, controller FSM states and default width.
//  Config      : SHIFT_ROTATE_OP_EN (see shift_stage / shift_seq_ctrl)
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  // Default datapath width; must be a power of two >= 4.
  localparam int DEFAULT_WIDTH = 32;

  // Operation encodings as presented on in_op.
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11   // rotate right when enabled, otherwise aliases SRL
  } op_e;

  // Controller FSM encodings.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shift_stage
//  Description : One combinational log-stage of the shifter. When en_i is
//                set, data_i is shifted by 2^k_i with the fill selected by
//                op_i; otherwise data_i passes through unchanged.
//  Ports       : data_i  - operand / partial result
//                op_i    - SLL / SRL / SRA / ROR (ROR aliases SRL unless
//                          SHIFT_ROTATE_OP_EN is defined)
//                k_i     - stage index, shift distance is 2^k_i
//                en_i    - apply this stage
//                data_o  - stage result
//  Config      : SHIFT_ROTATE_OP_EN - enables rotate-right on op 11
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH),
  parameter int KW    = $clog2(SHW)
) (
  input  logic [WIDTH-1:0] data_i,
  input  op_e              op_i,
  input  logic [KW-1:0]    k_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
);

  // Largest stage distance is WIDTH/2, which fits in SHW bits.
  logic [SHW-1:0]   w_dist;
  logic [WIDTH-1:0] w_shifted;
`ifdef SHIFT_ROTATE_OP_EN
  // Left shift that brings the LSBs back in at the top. Modulo-WIDTH
  // negation equals WIDTH - dist because dist is never zero.
  logic [SHW-1:0]   w_rot_l;
`endif

  always_comb begin
    w_dist = SHW'(1) << k_i;
`ifdef SHIFT_ROTATE_OP_EN
    w_rot_l = -w_dist;
`endif
    w_shifted = data_i >> w_dist;
    unique case (op_i)
      OP_SLL: w_shifted = data_i << w_dist;
      OP_SRL: w_shifted = data_i >> w_dist;
      // The MSB of the partial result always equals the latched operand
      // sign, since earlier SRA stages only ever replicate it.
      OP_SRA: w_shifted = $unsigned($signed(data_i) >>> w_dist);
`ifdef SHIFT_ROTATE_OP_EN
      OP_ROR: w_shifted = (data_i >> w_dist) | (data_i << w_rot_l);
`else
      OP_ROR: w_shifted = data_i >> w_dist;
`endif
      default: w_shifted = data_i >> w_dist;
    endcase
    data_o = en_i ? w_shifted : data_i;
  end

endmodule : shift_stage
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_ctrl
//  Description : Multi-cycle shift sequencer. A single log-stage shifter is
//                reused over SHW cycles to perform SLL/SRL/SRA (and ROR when
//                enabled) on a WIDTH-bit operand. Request and result use
//                valid/ready handshakes.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid/in_ready   - request handshake
//                in_op, in_a, in_b   - operation, operand, shift amount
//                                      (only in_b[SHW-1:0] is used)
//                out_valid/out_ready - result handshake
//                out_s               - result, stable while out_valid
//                busy                - high whenever not IDLE
//  Config      : SHIFT_ROTATE_OP_EN - op 11 becomes rotate-right
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             busy
);

  localparam int KW = $clog2(SHW);
  localparam logic [KW-1:0] c_LAST_STAGE = KW'(SHW - 1);

  state_e           state_q, state_d;
  logic [KW-1:0]    stage_q, stage_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0]   amt_q,   amt_d;
  op_e              op_q,    op_d;

  logic [WIDTH-1:0] w_stage_out;

  // Upper shift-amount bits are architecturally ignored.
  logic w_unused_b_hi;
  assign w_unused_b_hi = ^in_b[WIDTH-1:SHW];

  shift_stage #(
    .WIDTH (WIDTH),
    .SHW   (SHW),
    .KW    (KW)
  ) u_stage (
    .data_i (data_q),
    .op_i   (op_q),
    .k_i    (stage_q),
    .en_i   (amt_q[stage_q]),
    .data_o (w_stage_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= OP_SLL;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    data_d  = data_q;
    amt_d   = amt_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in_a;
          amt_d   = in_b[SHW-1:0];
          op_d    = op_e'(in_op);
          stage_d = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d = w_stage_out;
        if (stage_q == c_LAST_STAGE) begin
          state_d = S_DONE;
        end else begin
          stage_d = stage_q + KW'(1);
        end
      end
      S_DONE: begin
        // data_q is not touched here, so the result holds across stalls.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_s     = data_q;

endmodule : shift_seq_ctrl
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_shift_seq_ctrl
//  Description : Self-checking bench for shift_seq_ctrl. Expected results are
//                pushed to a scoreboard queue at acceptance and popped when
//                the DUT presents a result.
//  Config      : SHIFT_ROTATE_OP_EN (must match the RTL build)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq_ctrl;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int last_acc = 0;
  logic [WIDTH-1:0] sb_q[$];

  shift_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bit-serial reference: one single-bit shift per unit of amount.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r = a;
    int amt = int'(b[4:0]);
    for (int i = 0; i < amt; i++) begin
      case (op)
        2'b00: r = {r[30:0], 1'b0};
        2'b01: r = {1'b0, r[31:1]};
        2'b10: r = {a[31], r[31:1]};
`ifdef SHIFT_ROTATE_OP_EN
        default: r = {r[0], r[31:1]};
`else
        default: r = {1'b0, r[31:1]};
`endif
      endcase
    end
    return r;
  endfunction

  // Issue one request, wait for its result, compare, then hold off the
  // consumer for 'stall' cycles before accepting. Leaves time at posedge+1.
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input logic chk_rate);
    int w;
    int lat;
    logic [31:0] exp;
    logic [31:0] held;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk);
    sb_q.push_back(model(op, a, b));
    if (chk_rate) check("accept_interval", 32'(cyc - last_acc), 32'd7);
    last_acc = cyc;
    #1;
    in_valid = 1'b0;
    in_op = 2'($urandom); in_a = $urandom; in_b = $urandom;
    check("busy_shift", {30'd0, busy, in_ready}, 32'd2);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), 32'd6);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    check("result", out_s, exp);
    held = out_s;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", {30'd0, out_valid, in_ready}, 32'd2);
      check("stall_data", out_s, held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_release", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_s", out_s, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed patterns and boundaries.
    do_req(2'b10, 32'h8000_0000, 32'd4, 0, 1'b0);
    check("sra_neg_const", model(2'b10, 32'h8000_0000, 32'd4), 32'hF800_0000);
    do_req(2'b01, 32'h8000_0000, 32'd4, 0, 1'b0);
    do_req(2'b00, 32'h0000_0001, 32'd31, 0, 1'b0);
    do_req(2'b10, 32'hFFFF_FFF0, 32'd31, 0, 1'b0);
    for (int op = 0; op < 4; op++) do_req(2'(op), 32'h1234_5678, 32'd0, 0, 1'b0);
    do_req(2'b01, 32'h8000_0000, 32'h0000_0024, 0, 1'b0);
    do_req(2'b10, 32'h8000_0000, 32'hFFFF_FFE4, 0, 1'b0);
    do_req(2'b11, 32'h0000_000F, 32'd4, 0, 1'b0);
    do_req(2'b01, 32'h7FFF_FFFF, 32'd31, 0, 1'b0);

    // Backpressure, then back-to-back requests at the best rate.
    do_req(2'b00, 32'hA5A5_0F0F, 32'd7, 10, 1'b0);
    do_req(2'b10, 32'h9000_0001, 32'd3, 0, 1'b0);
    for (int i = 0; i < 3; i++) do_req(2'(i), $urandom, $urandom, 0, 1'b1);

    // Random mix.
    for (int i = 0; i < 12; i++) do_req(2'($urandom), $urandom, $urandom, 0, 1'b0);

    // Reset in the third SHIFT cycle discards the request.
    in_valid = 1'b1; in_op = 2'b01; in_a = 32'hCAFE_F00D; in_b = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_state", {29'd0, out_valid, in_ready, busy}, 32'd2);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("midrst_no_stale", 32'(seen), 32'd0);
    do_req(2'b00, 32'h0000_00FF, 32'd8, 0, 1'b0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_shift_seq_ctrl
`default_nettype wire
